class_hvec_stream: RTL and testbench
====================================

CLASS_HVEC_STREAM -- requirements
Module: class_hvec_stream

Interface
REQ-001 SHALL have parameter FRAME_W, default 64, bits per class hypervector frame.
REQ-002 SHALL have parameter NUM_CLASSES, default 8, number of stored classes.
REQ-003 SHALL have parameter NUM_FRAMES, default 3, frames per class; CID_W = max(1,$clog2(NUM_CLASSES)), FIDX_W = max(1,$clog2(NUM_FRAMES)).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  class readout request.
REQ-007 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_class_id  in  CID_W  class to stream.
REQ-009 SHALL have port out_valid  out  1  frame valid.
REQ-010 SHALL have port out_ready  in  1  downstream accepts frame.
REQ-011 SHALL have port out_frame  out  FRAME_W  class frame data.
REQ-012 SHALL have port out_class_id  out  CID_W  class of current frame.
REQ-013 SHALL have port out_frame_index  out  FIDX_W  frame index within class.
REQ-014 SHALL have port out_last  out  1  high with final frame (index NUM_FRAMES-1).
REQ-015 SHALL have port wr_en  in  1  frame write strobe (training/load).
REQ-016 SHALL have port wr_mode  in  1  0 = overwrite, 1 = XOR-update (mem ^= wr_data).
REQ-017 SHALL have port wr_class_id  in  CID_W  write target class.
REQ-018 SHALL have port wr_frame_index  in  FIDX_W  write target frame.
REQ-019 SHALL have port wr_data  in  FRAME_W  write data.
REQ-020 SHALL have port err  out  1  one-cycle pulse on out-of-range request or write.

Function
REQ-021 SHALL store NUM_CLASSES x NUM_FRAMES frames of FRAME_W bits in registers.
REQ-022 SHALL implement FSM IDLE/STREAM; req_ready = 1 only in IDLE.
REQ-023 IDLE: accepted request with req_class_id < NUM_CLASSES SHALL latch class, set index 0, load out_frame from mem[class][0], enter STREAM; out_valid high the next cycle (latency 1).
REQ-024 IDLE: accepted request with req_class_id >= NUM_CLASSES SHALL pulse err next cycle, stay IDLE, produce no frames.
REQ-025 STREAM: out_valid SHALL stay high; out_frame, out_class_id, out_frame_index, out_last SHALL remain stable while out_valid && !out_ready.
REQ-026 STREAM: on out_valid && out_ready with index < NUM_FRAMES-1, SHALL increment index and load next frame, out_valid staying high (one frame per cycle under continuous out_ready).
REQ-027 STREAM: on handshake with out_last, SHALL return to IDLE; out_valid low and req_ready high the next cycle.
REQ-028 Writes SHALL be accepted in any state, take effect at the clock edge, overwrite or XOR per wr_mode.
REQ-029 Write with wr_class_id >= NUM_CLASSES or wr_frame_index >= NUM_FRAMES SHALL be ignored and pulse err next cycle.
REQ-030 Write to the location being loaded into out_frame in the same cycle SHALL be forwarded (write-first: loaded value is post-write value).
REQ-031 Write to the location currently held on out_frame SHALL NOT alter out_frame; it updates memory only.
REQ-032 Simultaneous invalid request and invalid write SHALL produce a single err pulse.
REQ-033 NUM_FRAMES = 1: every frame SHALL have out_last = 1.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, all memory frames to 0, out_valid 0, out_frame 0, out_class_id 0, out_frame_index 0, out_last 0, err 0; req_ready 1 after release.
REQ-035 Reset mid-stream SHALL abort the burst; no further frames after rst_n release without a new request.

Verification
REQ-036 Load class 2 frames 0..2 with 64'hA5.., 64'h5A.., 64'hFF.. (overwrite); request class 2, out_ready = 1 -> three consecutive frames, indices 0,1,2, out_last only on 2, req_ready high the cycle after.
REQ-037 Same stream with out_ready toggling 1,0,0,1,... -> outputs stable during stalls, no frame dropped or repeated.
REQ-038 Class 5 frame 1 = 64'hF0F0..; XOR-write 64'hFFFF.. -> readback 64'h0F0F..; XOR again -> 64'hF0F0...
REQ-039 Write class 4 frame 1 in the same cycle as the frame-0 handshake of class 4 -> frame 1 output shows new data; write to frame 1 while it stalls on out_frame -> output unchanged, next readout shows new data.
REQ-040 NUM_CLASSES = 6: request class 7 -> err one cycle, no out_valid; write class 6 -> err, memory unchanged.
REQ-041 Assert rst_n low during frame 1 of a stream -> out_valid 0 immediately, all frames read back 0 afterwards.

Source files
------------

// File: rtl/class_hvec_stream.sv
// Register-file class hypervector store that streams one class as NUM_FRAMES frames on request.
// Latency 1 from request accept to first frame; frames hold while out_ready is low; writes forward into a same-cycle load.
module class_hvec_stream #(
  parameter int FRAME_W     = 64,
  parameter int NUM_CLASSES = 8,
  parameter int NUM_FRAMES  = 3,
  localparam int CID_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int FIDX_W = (NUM_FRAMES  > 1) ? $clog2(NUM_FRAMES)  : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CID_W-1:0]   req_class_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_frame,
  output logic [CID_W-1:0]   out_class_id,
  output logic [FIDX_W-1:0]  out_frame_index,
  output logic               out_last,
  input  logic               wr_en,
  input  logic               wr_mode,
  input  logic [CID_W-1:0]   wr_class_id,
  input  logic [FIDX_W-1:0]  wr_frame_index,
  input  logic [FRAME_W-1:0] wr_data,
  output logic               err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [CID_W:0]    CLS_LIM  = (CID_W+1)'(NUM_CLASSES);
  localparam logic [FIDX_W:0]   FRM_LIM  = (FIDX_W+1)'(NUM_FRAMES);
  localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FRAMES - 1);

  logic [FRAME_W-1:0] r_mem [NUM_CLASSES][NUM_FRAMES];
  logic [0:0]         r_state;
  logic [CID_W-1:0]   r_cls;
  logic [FIDX_W-1:0]  r_idx;
  logic [FRAME_W-1:0] r_frame;
  logic               r_last;
  logic               r_err;

  logic               w_req_cls_ok;
  logic               w_req_bad;
  logic               w_wr_ok;
  logic               w_wr_bad;
  logic [FRAME_W-1:0] w_wr_new;
  logic               w_ld_en;
  logic [CID_W-1:0]   w_ld_cls;
  logic [FIDX_W-1:0]  w_ld_idx;
  logic [FRAME_W-1:0] w_ld_dat;
  logic [0:0]         w_nxt_state;

  assign w_req_cls_ok = ({1'b0, req_class_id} < CLS_LIM);
  assign w_req_bad    = (r_state == S_IDLE) && req_valid && !w_req_cls_ok;
  assign w_wr_ok      = wr_en && ({1'b0, wr_class_id} < CLS_LIM) &&
                        ({1'b0, wr_frame_index} < FRM_LIM);
  assign w_wr_bad     = wr_en && !w_wr_ok;
  assign w_wr_new     = wr_mode ? (r_mem[wr_class_id][wr_frame_index] ^ wr_data) : wr_data;

  always_comb begin
    w_ld_en     = 1'b0;
    w_ld_cls    = r_cls;
    w_ld_idx    = r_idx;
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid && w_req_cls_ok) begin
          w_ld_en     = 1'b1;
          w_ld_cls    = req_class_id;
          w_ld_idx    = '0;
          w_nxt_state = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (r_last) begin
            w_nxt_state = S_IDLE;
          end else begin
            w_ld_en  = 1'b1;
            w_ld_idx = r_idx + FIDX_W'(1);
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Write-first: a write hitting the frame being loaded this cycle is seen by the load.
  assign w_ld_dat = (w_wr_ok && (wr_class_id == w_ld_cls) && (wr_frame_index == w_ld_idx))
                    ? w_wr_new : r_mem[w_ld_cls][w_ld_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
          r_mem[c][f] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      r_mem[wr_class_id][wr_frame_index] <= w_wr_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cls   <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_err   <= w_req_bad || w_wr_bad;
      if (w_ld_en) begin
        r_cls   <= w_ld_cls;
        r_idx   <= w_ld_idx;
        r_frame <= w_ld_dat;
        r_last  <= (w_ld_idx == LAST_IDX);
      end
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign out_valid       = (r_state == S_STREAM);
  assign out_frame       = r_frame;
  assign out_class_id    = r_cls;
  assign out_frame_index = r_idx;
  assign out_last        = r_last;
  assign err             = r_err;

endmodule

// File: tb/tb_class_hvec_stream.sv
// Bench for class_hvec_stream (6 classes x 3 frames x 64 bits): scoreboard of expected frames,
// model memory updated on every accepted write, all checks routed through chk.
module tb_class_hvec_stream;

  localparam int NC = 6;
  localparam int NF = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_class_id;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_frame;
  logic [2:0]  out_class_id;
  logic [1:0]  out_frame_index;
  logic        out_last;
  logic        wr_en;
  logic        wr_mode;
  logic [2:0]  wr_class_id;
  logic [1:0]  wr_frame_index;
  logic [63:0] wr_data;
  logic        err;

  typedef struct packed {
    logic [63:0] f;
    logic [2:0]  c;
    logic [1:0]  i;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_mem [NC][NF];
  int          n_tests = 0;
  int          n_fail  = 0;

  class_hvec_stream #(.FRAME_W(64), .NUM_CLASSES(NC), .NUM_FRAMES(NF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_class_id(req_class_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
    .out_class_id(out_class_id), .out_frame_index(out_frame_index), .out_last(out_last),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_class_id(wr_class_id),
    .wr_frame_index(wr_frame_index), .wr_data(wr_data), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic push_class(input int cls);
    exp_t e;
    for (int i = 0; i < NF; i++) begin
      e.f = m_mem[cls][i];
      e.c = 3'(cls);
      e.i = 2'(i);
      e.l = (i == NF - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_one(input logic [63:0] f, input int cls, input int i);
    exp_t e;
    e.f = f;
    e.c = 3'(cls);
    e.i = 2'(i);
    e.l = (i == NF - 1);
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic mode, input int cls, input int fi, input logic [63:0] d);
    logic bad;
    wr_en = 1'b1; wr_mode = mode; wr_class_id = 3'(cls); wr_frame_index = 2'(fi); wr_data = d;
    cyc_end();
    wr_en = 1'b0;
    bad = (cls >= NC) || (fi >= NF);
    if (!bad) m_mem[cls][fi] = mode ? (m_mem[cls][fi] ^ d) : d;
    chk("wr_err", err, bad);
  endtask

  // One negedge sample: valid frames must match the queue head; popped only on handshake.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexp_vld", out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        chk("frame", out_frame, e.f);
        chk("cls", out_class_id, e.c);
        chk("idx", out_frame_index, e.i);
        chk("last", out_last, e.l);
        if (out_ready) e = exp_q.pop_front();
      end
    end
  endtask

  task automatic request(input int cls, input bit push);
    req_valid = 1'b1;
    req_class_id = 3'(cls);
    if (push) push_class(cls);
    cyc_end();
    req_valid = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int exp_cyc);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      out_ready = pat[cyc % 4];
      sample();
      if (cyc == 0) chk("lat_vld", out_valid, 1'b1);
      cyc_end();
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    if (exp_cyc > 0) chk("burst_cyc", cyc, exp_cyc);
    chk("end_vld", out_valid, 1'b0);
    chk("end_rdy", req_ready, 1'b1);
  endtask

  task automatic stream(input int cls, input logic [3:0] pat, input int exp_cyc);
    request(cls, 1'b1);
    drain(pat, exp_cyc);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_class_id = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_mode = 1'b0; wr_class_id = '0; wr_frame_index = '0; wr_data = '0;
    for (int c = 0; c < NC; c++) for (int f = 0; f < NF; f++) m_mem[c][f] = '0;

    #12;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_frame", out_frame, 64'd0);
    chk("rst_cls", out_class_id, 3'd0);
    chk("rst_idx", out_frame_index, 2'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    cyc_end();
    chk("rst_rdy", req_ready, 1'b1);

    // Basic load and full-rate burst
    wr(1'b0, 2, 0, 64'hA5A5_A5A5_A5A5_A5A5);
    wr(1'b0, 2, 1, 64'h5A5A_5A5A_5A5A_5A5A);
    wr(1'b0, 2, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    stream(2, 4'b1111, 3);

    // Stalling downstream: 1,0,0,1 repeating
    stream(2, 4'b1001, 5);

    // XOR update round trip
    wr(1'b0, 5, 1, 64'hF0F0_F0F0_F0F0_F0F0);
    wr(1'b1, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    stream(5, 4'b1111, 3);
    wr(1'b1, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    stream(5, 4'b1011, 0);

    // Write forwarding into a load, and a write under a stalled frame
    wr(1'b0, 4, 0, 64'h1111_2222_3333_4444);
    wr(1'b0, 4, 1, 64'h5555_6666_7777_8888);
    wr(1'b0, 4, 2, 64'h9999_AAAA_BBBB_CCCC);
    push_one(m_mem[4][0], 4, 0);
    push_one(64'hDEAD_BEEF_0000_0001, 4, 1);
    push_one(m_mem[4][2], 4, 2);
    request(4, 1'b0);
    out_ready = 1'b1;
    wr_en = 1'b1; wr_mode = 1'b0; wr_class_id = 3'd4; wr_frame_index = 2'd1;
    wr_data = 64'hDEAD_BEEF_0000_0001;
    sample();
    cyc_end();
    wr_en = 1'b0;
    m_mem[4][1] = 64'hDEAD_BEEF_0000_0001;
    out_ready = 1'b0;
    sample();
    wr_en = 1'b1; wr_data = 64'hCAFE_F00D_0000_0002;
    cyc_end();
    wr_en = 1'b0;
    m_mem[4][1] = 64'hCAFE_F00D_0000_0002;
    sample();
    cyc_end();
    drain(4'b1111, 2);
    stream(4, 4'b1111, 3);

    // Out-of-range request and writes
    request(7, 1'b0);
    chk("badreq_err", err, 1'b1);
    chk("badreq_vld", out_valid, 1'b0);
    cyc_end();
    chk("badreq_err_end", err, 1'b0);
    chk("badreq_vld2", out_valid, 1'b0);
    chk("badreq_rdy", req_ready, 1'b1);
    wr(1'b0, 6, 0, 64'h0123_4567_89AB_CDEF);
    wr(1'b0, 1, 3, 64'h0123_4567_89AB_CDEF);
    stream(0, 4'b1111, 3);
    stream(2, 4'b1111, 3);

    // Invalid request and invalid write together give one pulse
    req_valid = 1'b1; req_class_id = 3'd7;
    wr_en = 1'b1; wr_mode = 1'b0; wr_class_id = 3'd6; wr_frame_index = 2'd0; wr_data = '1;
    cyc_end();
    req_valid = 1'b0; wr_en = 1'b0;
    chk("dual_err", err, 1'b1);
    cyc_end();
    chk("dual_err_end", err, 1'b0);

    // Reset during frame 1 of a burst
    request(2, 1'b1);
    out_ready = 1'b1;
    sample();
    cyc_end();
    out_ready = 1'b0;
    sample();
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", out_valid, 1'b0);
    chk("midrst_frame", out_frame, 64'd0);
    chk("midrst_rdy", req_ready, 1'b1);
    exp_q.delete();
    for (int c = 0; c < NC; c++) for (int f = 0; f < NF; f++) m_mem[c][f] = '0;
    cyc_end();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_vld", out_valid, 1'b0);
      cyc_end();
    end
    for (int c = 0; c < NC; c++) stream(c, 4'b1111, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
